// File: rtl/sum_block_accumulator.sv
// -----------------------------------------------------------------------------
// sum_block_accumulator
//
// Purpose:
//   Consumes a stream of 8-bit adder sums over a valid/ready handshake and
//   accumulates a programmable-length block of them into a saturating
//   ACC_W-bit total. The total is then emitted as two bytes (low byte first,
//   then high byte carrying the overflow flag in bit 7) over a second
//   valid/ready handshake. No new samples are taken while a result is pending.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   ena        - stage enable; low freezes all state and drops both handshakes
//   block_len  - samples per block, sampled on the first accept (0 = 2^LEN_W)
//   in_data    - unsigned sample
//   in_valid   - in_data valid
//   in_ready   - block can accept a sample
//   out_byte   - result byte (low, then high)
//   out_valid  - out_byte valid
//   out_ready  - consumer accepts out_byte
//   out_last   - high on the high result byte
//   busy       - block partially accumulated or result being emitted
// -----------------------------------------------------------------------------
module sum_block_accumulator #(
  parameter int ACC_W = 10,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [LEN_W-1:0] block_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_EMIT_LO = 2'd1,
    ST_EMIT_HI = 2'd2
  } state_e;

  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [LEN_W:0]   LEN_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]   CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W:0]   len_q, len_d;

  logic             accept_s;
  logic [ACC_W:0]   sum_s;
  logic [LEN_W:0]   blen_map_s;
  logic [LEN_W:0]   target_s;
  logic [LEN_W:0]   cnt_inc_s;
  logic [6:0]       hi7_s;

  // Handshake and status outputs; in_ready is also forced low during reset.
  always_comb begin
    in_ready  = rst_n & ena & (state_q == ST_ACC);
    out_valid = ena & ((state_q == ST_EMIT_LO) | (state_q == ST_EMIT_HI));
    busy      = (cnt_q != {(LEN_W+1){1'b0}}) | (state_q != ST_ACC);
  end

  assign accept_s   = in_valid & in_ready;
  // One spare bit catches the carry that signals saturation.
  assign sum_s      = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_data};
  assign blen_map_s = (block_len == {LEN_W{1'b0}}) ? LEN_FULL : {1'b0, block_len};
  // On the first sample of a block len_q is not yet loaded, so compare
  // against the freshly mapped block_len instead.
  assign target_s   = (cnt_q == {(LEN_W+1){1'b0}}) ? blen_map_s : len_q;
  assign cnt_inc_s  = cnt_q + CNT_ONE;
  // Upper accumulator bits right-aligned into the 7 bits below the ovf flag.
  assign hi7_s      = 7'(acc_q >> 4'd8);

  // Next-state logic for the block FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    len_d   = len_q;
    if (ena) begin
      case (state_q)
        ST_ACC: begin
          if (accept_s) begin
            if (cnt_q == {(LEN_W+1){1'b0}}) begin
              len_d = blen_map_s;
            end else begin
              len_d = len_q;
            end
            if (sum_s[ACC_W]) begin
              acc_d = ACC_MAX;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_s[ACC_W-1:0];
              ovf_d = ovf_q;
            end
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == target_s) begin
              state_d = ST_EMIT_LO;
            end else begin
              state_d = ST_ACC;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_EMIT_LO: begin
          if (out_ready) begin
            state_d = ST_EMIT_HI;
          end else begin
            state_d = state_q;
          end
        end
        ST_EMIT_HI: begin
          if (out_ready) begin
            state_d = ST_ACC;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {(LEN_W+1){1'b0}};
            ovf_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean empty block.
          state_d = ST_ACC;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {(LEN_W+1){1'b0}};
          ovf_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Result byte selection; zero outside the emit states (and so in reset).
  always_comb begin
    out_byte = 8'h00;
    out_last = 1'b0;
    case (state_q)
      ST_EMIT_LO: begin
        out_byte = acc_q[7:0];
        out_last = 1'b0;
      end
      ST_EMIT_HI: begin
        out_byte = {ovf_q, hi7_s};
        out_last = 1'b1;
      end
      default: begin
        out_byte = 8'h00;
        out_last = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {(LEN_W+1){1'b0}};
      ovf_q   <= 1'b0;
      len_q   <= {(LEN_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Directed testbench for sum_block_accumulator. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_sum_block_accumulator;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] block_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  int n_cmp;
  int n_err;

  logic [7:0] smp [16];
  logic [7:0] lo_b, hi_b;
  logic       lo_last, hi_last;
  logic       early_out;

  sum_block_accumulator #(.ACC_W(10), .LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .block_len (block_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drives n samples from smp[], one per cycle whenever in_ready is high.
  // Starts and ends on a falling edge.
  task automatic send_samples(input int n, input logic [3:0] blen);
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    early_out = 1'b0;
    block_len = blen;
    while (sent < n && cyc < 200) begin
      if (out_valid) early_out = 1'b1;
      if (in_ready) begin
        in_valid = 1'b1;
        in_data = smp[sent];
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sent != n) begin
      n_err++;
      $display("FAIL send_timeout: sent %0d samples, required %0d", sent, n);
    end
  endtask

  // Collects the two result bytes with out_ready held high.
  task automatic collect();
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (got < 2 && cyc < 50) begin
      if (out_valid) begin
        if (got == 0) begin
          lo_b = out_byte;
          lo_last = out_last;
        end else begin
          hi_b = out_byte;
          hi_last = out_last;
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (got != 2) begin
      n_err++;
      $display("FAIL collect_timeout: got %0d bytes, required 2", got);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_byte !== 8'h00) begin n_err++; $display("FAIL rst_out_byte: got %h expected 00", out_byte); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rel_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30;
    send_samples(3, 4'd3);
    n_cmp++; if (early_out !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b expected 0", early_out); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_low: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
    collect();
    n_cmp++; if (lo_b !== 8'h3C) begin n_err++; $display("FAIL basic_lo: got %h expected 3c", lo_b); end
    n_cmp++; if (lo_last !== 1'b0) begin n_err++; $display("FAIL basic_lo_last: got %b expected 0", lo_last); end
    n_cmp++; if (hi_b !== 8'h00) begin n_err++; $display("FAIL basic_hi: got %h expected 00", hi_b); end
    n_cmp++; if (hi_last !== 1'b1) begin n_err++; $display("FAIL basic_hi_last: got %b expected 1", hi_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back: got %b expected 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) smp[i] = 8'hFF;
    send_samples(5, 4'd5);
    collect();
    n_cmp++; if (lo_b !== 8'hFF) begin n_err++; $display("FAIL ovf_lo: got %h expected ff", lo_b); end
    n_cmp++; if (hi_b !== 8'h83) begin n_err++; $display("FAIL ovf_hi: got %h expected 83", hi_b); end
    smp[0] = 8'h01;
    send_samples(1, 4'd1);
    collect();
    n_cmp++; if (lo_b !== 8'h01) begin n_err++; $display("FAIL ovf_clr_lo: got %h expected 01", lo_b); end
    n_cmp++; if (hi_b !== 8'h00) begin n_err++; $display("FAIL ovf_clr_hi: got %h expected 00", hi_b); end
  endtask

  task automatic test_full_block();
    for (int i = 0; i < 16; i++) smp[i] = 8'h01;
    send_samples(16, 4'd0);
    n_cmp++; if (early_out !== 1'b0) begin n_err++; $display("FAIL full_early: got %b expected 0", early_out); end
    collect();
    n_cmp++; if (lo_b !== 8'h10) begin n_err++; $display("FAIL full_lo: got %h expected 10", lo_b); end
    n_cmp++; if (hi_b !== 8'h00) begin n_err++; $display("FAIL full_hi: got %h expected 00", hi_b); end
  endtask

  task automatic test_backpressure();
    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30;
    send_samples(3, 4'd3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd99;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_byte !== 8'h3C) begin n_err++; $display("FAIL bp_byte[%0d]: got %h expected 3c", i, out_byte); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect();
    n_cmp++; if (lo_b !== 8'h3C) begin n_err++; $display("FAIL bp_lo: got %h expected 3c", lo_b); end
    n_cmp++; if (hi_b !== 8'h00) begin n_err++; $display("FAIL bp_hi: got %h expected 00", hi_b); end
  endtask

  task automatic test_enable();
    smp[0] = 8'd10; smp[1] = 8'd20;
    send_samples(2, 4'd3);
    ena = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ena_ready[%0d]: got %b expected 0", i, in_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ena_busy[%0d]: got %b expected 1", i, busy); end
    end
    in_valid = 1'b0;
    ena = 1'b1;
    smp[0] = 8'd5;
    // block_len differs here on purpose: it must be ignored mid-block.
    send_samples(1, 4'd7);
    collect();
    n_cmp++; if (lo_b !== 8'h23) begin n_err++; $display("FAIL ena_lo: got %h expected 23", lo_b); end
    n_cmp++; if (hi_b !== 8'h00) begin n_err++; $display("FAIL ena_hi: got %h expected 00", hi_b); end
  endtask

  task automatic test_async_reset();
    smp[0] = 8'h42;
    send_samples(1, 4'd1);
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL ar_in_hi: got %b expected 1", out_last); end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ar_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready_back: got %b expected 1", in_ready); end
    smp[0] = 8'h07;
    send_samples(1, 4'd1);
    collect();
    n_cmp++; if (lo_b !== 8'h07) begin n_err++; $display("FAIL ar_lo: got %h expected 07", lo_b); end
    n_cmp++; if (hi_b !== 8'h00) begin n_err++; $display("FAIL ar_hi: got %h expected 00", hi_b); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    ena = 1'b1;
    block_len = 4'd0;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    lo_b = 8'h00; hi_b = 8'h00; lo_last = 1'b0; hi_last = 1'b0;
    early_out = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_block();
    test_backpressure();
    test_enable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the chip's 8-bit adder output: takes a stream of 8-bit sums over a valid/ready handshake and accumulates a programmable-length block of them.
- Emits the saturated block total as two bytes, low byte then high byte, over a second valid/ready handshake.
- Sits between the adder and the uo_out/uio output muxing in the top level.

Parameters:
- ACC_W, 10, accumulator width in bits. Legal range 9..15. Sum saturates at 2^ACC_W-1.
- LEN_W, 4, width of block_len. Maximum block is 2^LEN_W samples.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- ena  input  1  stage enable. Low freezes the block.
- block_len  input  LEN_W  samples per block. Value 0 means 2^LEN_W.
- in_data  input  8  unsigned sample (adder sum)
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a sample
- out_byte  output  8  result byte
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts out_byte
- out_last  output  1  high on the second (high) result byte
- busy  output  1  high while a block is partially accumulated or being emitted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low; release is synchronous to clk.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, len_q=0. While rst_n is low: in_ready=0, out_valid=0, out_last=0, out_byte=0, busy=0.
- FSM states: ACC, EMIT_LO, EMIT_HI.
- Handshake strobes: accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- in_ready = ena & (state==ACC), combinational.
- out_valid = ena & (state is EMIT_LO or EMIT_HI).
- ena low: FSM, acc, cnt and all registers hold; in_ready=0 and out_valid=0.

- ACC, on accept:
  - If cnt==0, latch block_len into len_q (0 maps to 2^LEN_W). block_len is ignored at all other times.
  - Sum = acc + zero-extended in_data. If the sum exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and ovf <= 1 (sticky for the block). Otherwise acc <= sum.
  - cnt <= cnt+1. On the accept that makes cnt equal len_q, state <= EMIT_LO on the next edge and cnt holds.
- ACC, no accept: hold everything.
- Latency: out_valid rises the first cycle after the final accept.

- EMIT_LO:
  - out_byte = acc[7:0], out_last=0.
  - On transfer, state <= EMIT_HI.
- EMIT_HI:
  - out_byte = {ovf, zeros, acc[ACC_W-1:8]}: ovf in bit 7, upper accumulator bits right-aligned, zero-padded between.
  - out_last=1.
  - On transfer: state <= ACC, acc <= 0, cnt <= 0, ovf <= 0. in_ready is high the next cycle (if ena=1).
- Output stability: out_byte and out_last hold while out_valid=1 and out_ready=0.
- No input/output overlap: in_ready is 0 in both EMIT states, so the next block is never accepted while a result is pending. Maximum throughput is len_q samples per len_q+2 cycles with out_ready tied high.
- busy = (cnt!=0) | (state!=ACC).
- Reset mid-operation: any partial block or pending result is discarded. After release, state is ACC with a cleared accumulator.
- Single-sample block: block_len=1 gives ACC -> EMIT_LO after one accept.

Test Plan:
- Reset, then block_len=3, samples 10,20,30 with in_valid held high, out_ready=1 -> in_ready low after the third accept. Next cycle out_byte=0x3C with out_last=0, then 0x00 with out_last=1. in_ready returns high the following cycle.
- block_len=5, five samples of 0xFF (total 1275 > 1023) -> low byte 0xFF, high byte 0x83 (ovf=1, acc=0x3FF). The following block of one sample 0x01 (block_len=1) yields 0x01, 0x00 (ovf cleared).
- block_len=0, sixteen samples of 0x01 -> exactly 16 accepts, then 0x10, 0x00. No output appears after 15 samples.
- Backpressure: out_ready=0 for 4 cycles during EMIT_LO of a 0x3C result -> out_byte stays 0x3C and out_valid stays 1. in_valid high in this window gives in_ready=0 and no accept. Release -> normal two-byte transfer.
- ena=0 mid-block, after 2 of 3 samples (30 so far), for 5 cycles with in_valid=1 -> no accepts, busy=1. ena=1 and one sample 5 -> result 0x23, 0x00.
- Assert rst_n low asynchronously, between clock edges, during EMIT_HI -> out_valid and in_ready drop immediately. After release: busy=0, in_ready=1, and a 1-sample block of 0x07 yields 0x07, 0x00.
